// File: rtl/wb_pkg.sv
// Shared constants and the writeback request type for the writeback unit.
package wb_pkg;

  localparam int XLEN         = 64;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rdAddr;
    logic [XLEN-1:0]       data;
  } wb_req;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write busy bits for x1..x31; x0 is hard-wired not busy.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       set_en,
  input  logic [REG_ADDR_W-1:0]      set_addr,
  input  logic                       clr_en,
  input  logic [REG_ADDR_W-1:0]      clr_addr,
  input  logic [2:0][REG_ADDR_W-1:0] rd_addr,
  output logic [2:0]                 rd_busy,
  output logic                       clr_busy
);

  logic [NUM_REGS-1:0] busy_reg;

  assign busy_reg[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      // A same-edge set beats the clear so a re-issued register stays pending.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          busy_reg[gi] <= 1'b0;
        end else if (set_en && set_addr == REG_ADDR_W'(gi)) begin
          busy_reg[gi] <= 1'b1;
        end else if (clr_en && clr_addr == REG_ADDR_W'(gi)) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end

    for (gi = 0; gi < 3; gi++) begin : g_rd
      assign rd_busy[gi] = busy_reg[rd_addr[gi]];
    end
  endgenerate

  assign clr_busy = busy_reg[clr_addr];

endmodule

// File: rtl/wb_unit.sv
// Writeback arbiter: merges ALU and LSU results into one register-file write
// port, with LSU priority bounded by an ALU starvation counter.
module wb_unit
  import wb_pkg::*;
#(
  parameter int XLEN         = wb_pkg::XLEN,
  parameter int STARVE_LIMIT = wb_pkg::STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rdAddr,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
  output logic                  rs1Busy,
  output logic                  rs2Busy,
  output logic                  rdBusy,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rdAddr,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rdAddr,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  regCtrl_wen,
  output logic [REG_ADDR_W-1:0] regCtrl_rdAddr,
  output logic [XLEN-1:0]       rdData,
  output logic                  wbErr
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      starve_cnt_reg;
  logic                  wen_reg;
  logic [REG_ADDR_W-1:0] wr_addr_reg;
  logic [XLEN-1:0]       wr_data_reg;
  logic                  wb_err_reg;
  logic                  starved;
  logic                  lsu_xfer;
  logic                  alu_xfer;
  logic                  clr_busy;
  logic [2:0]            rd_busy;

  assign starved   = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
  // Readies are gated by reset so nothing can be accepted while it is held.
  assign lsu_ready = reset & ~starved;
  assign alu_ready = reset & (~lsu_valid | starved);
  assign lsu_xfer  = lsu_valid & lsu_ready;
  assign alu_xfer  = alu_valid & alu_ready & ~lsu_xfer;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= '0;
    end else if (alu_xfer) begin
      starve_cnt_reg <= '0;
    end else if (alu_valid && !alu_ready && !starved) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wen_reg     <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else if (lsu_xfer) begin
      wen_reg     <= (lsu_rdAddr != '0);
      wr_addr_reg <= lsu_rdAddr;
      wr_data_reg <= lsu_data;
    end else if (alu_xfer) begin
      wen_reg     <= (alu_rdAddr != '0);
      wr_addr_reg <= alu_rdAddr;
      wr_data_reg <= alu_data;
    end else begin
      wen_reg     <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_err_reg <= 1'b0;
    end else if (wen_reg && !clr_busy) begin
      wb_err_reg <= 1'b1;
    end
  end

  wb_scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (iss_valid),
    .set_addr (iss_rdAddr),
    .clr_en   (wen_reg),
    .clr_addr (wr_addr_reg),
    .rd_addr  ({iss_rdAddr, rs2Addr, rs1Addr}),
    .rd_busy  (rd_busy),
    .clr_busy (clr_busy)
  );

  assign rs1Busy        = rd_busy[0];
  assign rs2Busy        = rd_busy[1];
  assign rdBusy         = rd_busy[2];
  assign regCtrl_wen    = wen_reg;
  assign regCtrl_rdAddr = wr_addr_reg;
  assign rdData         = wr_data_reg;
  assign wbErr          = wb_err_reg;

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width of the integer register file.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive cycles an ALU result may wait before it takes priority.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port iss_valid  in  1  an instruction writing a destination register issues this cycle.
REQ-006 SHALL have port iss_rdAddr  in  5  destination register of the issuing instruction.
REQ-007 SHALL have ports rs1Addr, rs2Addr  in  5 each  source registers queried by issue.
REQ-008 SHALL have ports rs1Busy, rs2Busy, rdBusy  out  1 each  combinational pending-write flags for rs1Addr, rs2Addr and iss_rdAddr.
REQ-009 SHALL have ports alu_valid/alu_ready  in/out  1  ALU result handshake; alu_rdAddr  in  5; alu_data  in  XLEN.
REQ-010 SHALL have ports lsu_valid/lsu_ready  in/out  1  load result handshake; lsu_rdAddr  in  5; lsu_data  in  XLEN.
REQ-011 SHALL have ports regCtrl_wen  out  1, regCtrl_rdAddr  out  5, rdData  out  XLEN, all registered, driving the register file write port.
REQ-012 SHALL have port wbErr  out  1  sticky flag: a writeback targeted a register that was not busy.

Function
REQ-013 A transfer SHALL occur on a source when its valid and ready are both high at a rising edge; a source holds valid, rdAddr and data stable until the transfer.
REQ-014 SHALL accept at most one result per cycle.
REQ-015 Arbitration: the LSU SHALL have fixed priority; lsu_ready SHALL be 1 except when the ALU is in starvation state; alu_ready SHALL be 1 when lsu_valid is 0 or the ALU is in starvation state.
REQ-016 A starvation counter SHALL increment each cycle alu_valid is 1 and alu_ready is 0, SHALL saturate at STARVE_LIMIT, and SHALL clear on an ALU transfer; the ALU is in starvation state when the counter equals STARVE_LIMIT.
REQ-017 A transfer accepted at edge T SHALL drive regCtrl_wen=1 with the matching regCtrl_rdAddr and rdData during cycle T..T+1, giving 1-cycle latency; with no transfer, regCtrl_wen SHALL be 0, and regCtrl_rdAddr and rdData SHALL hold their values.
REQ-018 A transfer with rdAddr 0 SHALL be consumed with regCtrl_wen forced to 0.
REQ-019 The scoreboard SHALL hold 31 busy bits for x1..x31; x0 SHALL read as never busy.
REQ-020 iss_valid with iss_rdAddr != 0 SHALL set the busy bit at the edge.
REQ-021 regCtrl_wen=1 SHALL clear the busy bit of regCtrl_rdAddr at the same edge the register file captures the data.
REQ-022 When a set and a clear of the same register occur at the same edge, the set SHALL win and the bit SHALL be 1.
REQ-023 Busy outputs SHALL reflect registered state only, with no same-cycle bypass of iss_valid.
REQ-024 Issue SHALL NOT assert iss_valid while rdBusy=1; wb_unit need not handle a second outstanding write to the same register.
REQ-025 wbErr SHALL be set when regCtrl_wen=1 and the busy bit of regCtrl_rdAddr is 0; it SHALL clear only on reset.

Reset
REQ-026 When reset=0, all state SHALL clear asynchronously: regCtrl_wen=0, regCtrl_rdAddr=0, rdData=0, all busy bits 0, starvation counter 0, wbErr=0.
REQ-027 During reset, alu_ready and lsu_ready SHALL be 0; a write in flight when reset asserts SHALL be discarded.
REQ-028 Reset deassertion SHALL be synchronised externally; the first transfer may occur at the first edge after deassertion.

Structure
REQ-029 A shared package wb_pkg SHALL hold XLEN, REG_ADDR_W=5, NUM_REGS=32, the default STARVE_LIMIT, and a wb_req struct {rdAddr, data}.
REQ-030 The busy-bit array SHALL be a sub-module wb_scoreboard, with set port, clear port and three read ports.
REQ-031 Arbiter, starvation counter and output register SHALL reside in wb_unit.

Verification
REQ-032 Issue x5 -> rdBusy/rs1Busy(x5)=1 next cycle; ALU result x5=0x1234 -> regCtrl_wen=1, rdData=0x1234 one cycle later; busy=0 the cycle after.
REQ-033 ALU and LSU valid together for x3/x4 -> LSU x4 written first, ALU x3 the next cycle, wbErr stays 0.
REQ-034 LSU valid continuously for 6 cycles with ALU valid -> ALU transfers on the 5th cycle (STARVE_LIMIT=4), then LSU resumes.
REQ-035 Issue x7 in the same cycle as regCtrl_wen for x7 -> x7 stays busy; result to x0 -> regCtrl_wen stays 0.
REQ-036 Writeback to non-busy x9 -> wbErr=1 and sticky; reset pulse mid-transfer -> all outputs 0 immediately, busy bits cleared.
